// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan engine: fetches top/bottom pixel pairs from the frame buffer,
// shifts one BCM bit plane per row, latches it and displays it for a
// binary-weighted time. Optional macro HUB75_BRIGHTNESS_EN adds a global
// brightness input that shortens the oe-low window inside each DISPLAY.
module hub75_scan_ctrl #(
    parameter int WIDTH      = 96,
    parameter int HEIGHT     = 48,
    parameter int BPC        = 4,
    parameter int CHAINED    = 1,
    parameter int CLK_DIV    = 2,
    parameter int BASE_TIME  = 32,
    parameter int ADDR_LINES = 5,
    parameter int AW         = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]            brightness,
`endif
    output logic [AW-1:0]         fb_addr,
    output logic                  fb_rd,
    input  logic [3*BPC-1:0]      fb_data,
    output logic                  sclk,
    output logic                  lat,
    output logic                  oe,
    output logic [ADDR_LINES-1:0] row_addr,
    output logic                  r0,
    output logic                  g0,
    output logic                  b0,
    output logic                  r1,
    output logic                  g1,
    output logic                  b1,
    output logic                  frame_done
);

    localparam int W_TOT    = WIDTH * CHAINED;
    localparam int HALF     = HEIGHT / 2;
    localparam int COLW     = (W_TOT > 1) ? $clog2(W_TOT) : 1;
    localparam int ROWW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PLW      = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int DISP_MAX = BASE_TIME << (BPC - 1);
    localparam int MAXC     = (DISP_MAX > CLK_DIV) ? DISP_MAX : CLK_DIV;
    localparam int CW       = $clog2(MAXC + 1);
    localparam int PW       = 3 * BPC;

    typedef enum logic [3:0] {
        IDLE, RD_TOP, RD_BOT, CAP, SH_LO, SH_HI, BLANK, LATCH, DISPLAY
    } state_t;

    state_t                state_q, state_d;
    logic [COLW-1:0]       col_q, col_d;
    logic [ROWW-1:0]       row_q, row_d;
    logic [PLW-1:0]        plane_q, plane_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         top_q, top_d;
    logic [PW-1:0]         bot_q, bot_d;
    logic [AW-1:0]         fb_addr_q, fb_addr_d;
    logic                  fb_rd_q, fb_rd_d;
    logic                  sclk_q, sclk_d;
    logic                  lat_q, lat_d;
    logic                  oe_q, oe_d;
    logic [ADDR_LINES-1:0] row_addr_q, row_addr_d;
    logic [2:0]            rgb0_q, rgb0_d;
    logic [2:0]            rgb1_q, rgb1_d;
    logic                  frame_done_q, frame_done_d;
    logic [CW-1:0]         disp_len;
    logic [AW-1:0]         top_a, bot_a;
    logic                  disp_on;

    assign disp_len = CW'(BASE_TIME) << plane_q;

`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]  br_q, br_d;
    logic [31:0] on_prod, on_lim;
    // oe stays low while (cnt+1)*256 <= len*brightness, i.e. cnt < (len*brightness)>>8
    assign on_prod = (32'(BASE_TIME) << plane_q) * 32'(br_q);
    assign on_lim  = (32'(cnt_d) + 32'd1) << 8;
    assign disp_on = (on_lim <= on_prod);
`else
    assign disp_on = 1'b1;
`endif

    // Next-state, counters, pixel capture and registered-output values
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        plane_d      = plane_q;
        cnt_d        = cnt_q;
        top_d        = top_q;
        bot_d        = bot_q;
        rgb0_d       = rgb0_q;
        rgb1_d       = rgb1_q;
        frame_done_d = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
        br_d         = br_q;
`endif
        case (state_q)
            IDLE: if (en) state_d = RD_TOP;
            RD_TOP: begin
`ifdef HUB75_BRIGHTNESS_EN
                if (row_q == '0 && plane_q == '0 && col_q == '0) br_d = brightness;
`endif
                state_d = RD_BOT;
            end
            RD_BOT: begin
                top_d   = fb_data;
                state_d = CAP;
            end
            CAP: begin
                bot_d   = fb_data;
                // present this plane's bits as SH_LO begins
                rgb0_d  = {top_q[2*BPC + int'(plane_q)], top_q[BPC + int'(plane_q)], top_q[int'(plane_q)]};
                rgb1_d  = {fb_data[2*BPC + int'(plane_q)], fb_data[BPC + int'(plane_q)], fb_data[int'(plane_q)]};
                cnt_d   = '0;
                state_d = SH_LO;
            end
            SH_LO: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = SH_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SH_HI: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (col_q != COLW'(W_TOT - 1)) begin
                        col_d   = col_q + COLW'(1);
                        state_d = RD_TOP;
                    end else begin
                        col_d   = '0;
                        state_d = BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BLANK: state_d = LATCH;
            LATCH: begin
                cnt_d   = '0;
                state_d = DISPLAY;
            end
            DISPLAY: begin
                if (cnt_q == disp_len - CW'(1)) begin
                    cnt_d = '0;
                    if (plane_q != PLW'(BPC - 1)) begin
                        plane_d = plane_q + PLW'(1);
                    end else begin
                        plane_d = '0;
                        if (row_q != ROWW'(HALF - 1)) begin
                            row_d = row_q + ROWW'(1);
                        end else begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end
                    end
                    // en only matters at plane boundaries; a dropped en finishes the plane
                    state_d = en ? RD_TOP : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin values decoded from the state being entered so they are registered
    always_comb begin
        top_a      = AW'(row_d) * AW'(W_TOT) + AW'(col_d);
        bot_a      = (AW'(row_d) + AW'(HALF)) * AW'(W_TOT) + AW'(col_d);
        fb_rd_d    = (state_d == RD_TOP) || (state_d == RD_BOT);
        fb_addr_d  = fb_addr_q;
        if (state_d == RD_TOP) fb_addr_d = top_a;
        if (state_d == RD_BOT) fb_addr_d = bot_a;
        sclk_d     = (state_d == SH_HI);
        lat_d      = (state_d == LATCH);
        oe_d       = !((state_d == DISPLAY) && disp_on);
        row_addr_d = (state_d == BLANK) ? ADDR_LINES'(row_q) : row_addr_q;
    end

    // All state and outputs; reset overrides everything, including mid-frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            cnt_q        <= '0;
            top_q        <= '0;
            bot_q        <= '0;
            fb_addr_q    <= '0;
            fb_rd_q      <= 1'b0;
            sclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_q         <= 1'b1;
            row_addr_q   <= '0;
            rgb0_q       <= '0;
            rgb1_q       <= '0;
            frame_done_q <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
            br_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            cnt_q        <= cnt_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            fb_addr_q    <= fb_addr_d;
            fb_rd_q      <= fb_rd_d;
            sclk_q       <= sclk_d;
            lat_q        <= lat_d;
            oe_q         <= oe_d;
            row_addr_q   <= row_addr_d;
            rgb0_q       <= rgb0_d;
            rgb1_q       <= rgb1_d;
            frame_done_q <= frame_done_d;
`ifdef HUB75_BRIGHTNESS_EN
            br_q         <= br_d;
`endif
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_rd      = fb_rd_q;
    assign sclk       = sclk_q;
    assign lat        = lat_q;
    assign oe         = oe_q;
    assign row_addr   = row_addr_q;
    assign {r0, g0, b0} = rgb0_q;
    assign {r1, g1, b1} = rgb1_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl on a 4x4 panel, BPC=2, CLK_DIV=1, BASE_TIME=4.
module tb_hub75_scan_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int BT = 4;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [13:0] fb_addr;
    logic       fb_rd;
    logic [5:0] fb_data;
    logic       sclk, lat, oe, frame_done;
    logic [4:0] row_addr;
    logic       r0, g0, b0, r1, g1, b1;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0] brightness;
    int         bright;
`endif

    logic [5:0] mem [0:255];
    int         q_addr[$];
    logic [5:0] q_rgb[$];
    int         q_row[$];
    int         q_oe[$];
    int         checks = 0;
    int         failures = 0;
    int         fd_cnt = 0;
    int         oe_low = 0;
    bit         strict = 1'b0;

    hub75_scan_ctrl #(
        .WIDTH(W), .HEIGHT(H), .BPC(2), .CHAINED(1), .CLK_DIV(1),
        .BASE_TIME(BT), .ADDR_LINES(5), .AW(14)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
        .sclk(sclk), .lat(lat), .oe(oe), .row_addr(row_addr),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // read port: data one cycle after the strobe, junk otherwise
    always @(posedge clk) fb_data <= fb_rd ? mem[fb_addr[7:0]] : 6'($urandom);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_rgb(input logic [5:0] t, input logic [5:0] b, input int p);
        return {t[4+p], t[2+p], t[p], b[4+p], b[2+p], b[p]};
    endfunction

    function automatic int on_len(input int p);
`ifdef HUB75_BRIGHTNESS_EN
        return ((BT << p) * bright) >> 8;
`else
        return BT << p;
`endif
    endfunction

    // expected traffic for one row/plane, derived from the memory image
    task automatic push_rp(input int r, input int p);
        for (int c = 0; c < W; c++) begin
            q_addr.push_back(r * W + c);
            q_addr.push_back((r + H/2) * W + c);
            q_rgb.push_back(exp_rgb(mem[r*W+c], mem[(r+H/2)*W+c], p));
        end
        q_row.push_back(r);
        if (on_len(p) > 0) q_oe.push_back(on_len(p));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit q_empty();
        return q_addr.size() == 0 && q_rgb.size() == 0 && q_row.size() == 0 && q_oe.size() == 0;
    endfunction

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (!q_empty() && k < budget) begin
            tick(1);
            k++;
        end
        chk({tag, "_drained"}, 32'(q_empty()), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        q_addr.delete();
        q_rgb.delete();
        q_row.delete();
        q_oe.delete();
    endtask

    // monitor: pops the scoreboard as the panel pins produce events
    initial begin
        int run = 0;
        logic sclk_p = 1'b0, lat_p = 1'b0, fd_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (fb_rd) begin
                    if (q_addr.size() > 0) chk("fb_addr", 32'(fb_addr), q_addr.pop_front());
                    else if (strict) chk("idle_fb_rd", 32'(fb_rd), 0);
                end
                if (sclk && !sclk_p && q_rgb.size() > 0)
                    chk("rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'(q_rgb.pop_front()));
                if (lat) begin
                    chk("lat_vs_oe", 32'(oe), 1);
                    chk("lat_width", 32'(lat_p), 0);
                    if (q_row.size() > 0) chk("row_addr", 32'(row_addr), q_row.pop_front());
                end
                if (!oe) begin
                    run++;
                    oe_low++;
                end else if (run > 0) begin
                    if (q_oe.size() > 0) chk("oe_len", run, q_oe.pop_front());
                    run = 0;
                end
                if (frame_done) begin
                    fd_cnt++;
                    chk("fd_width", 32'(fd_p), 0);
                end
            end
            sclk_p = sclk;
            lat_p  = lat;
            fd_p   = frame_done;
        end
    end

    initial begin
        int fd0, k, lo0;
        rst = 1'b1;
        en  = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
        bright = 255;
        brightness = 8'd255;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 6'h3F;
        tick(3);
        // reset values
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_lat", 32'(lat), 0);
        chk("rst_oe", 32'(oe), 1);
        chk("rst_row_addr", 32'(row_addr), 0);
        chk("rst_rgb", 32'({r0, g0, b0, r1, g1, b1}), 0);
        chk("rst_fb_rd", 32'(fb_rd), 0);
        chk("rst_fb_addr", 32'(fb_addr), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        rst = 1'b0;
        tick(5);
        chk("idle_oe", 32'(oe), 1);
        chk("idle_no_rd", 32'(fb_rd), 0);

        // all-ones frame: full frame, row_addr 0,0,1,1, then restart at address 0
        for (int r = 0; r < H/2; r++)
            for (int p = 0; p < 2; p++) push_rp(r, p);
        q_addr.push_back(0);
        q_addr.push_back(8);
        fd0 = fd_cnt;
        en = 1'b1;
        drain("t1_frame", 2000);
        chk("t1_frame_done", fd_cnt - fd0, 1);

        // single set bits: R msb at address 1, B lsb at address 9
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 6'h00;
        mem[1] = 6'h20;
        mem[9] = 6'h01;
        push_rp(0, 0);
        push_rp(0, 1);
        rst = 1'b0;
        drain("t2_bits", 1000);

        // en dropped mid-shift: plane 0 finishes, idles, resumes on plane 1
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 6'(i * 37);
        push_rp(0, 0);
        rst = 1'b0;
        tick(5);
        en = 1'b0;
        drain("t4_plane0", 1000);
        strict = 1'b1;
        tick(20);
        chk("t4_idle_oe", 32'(oe), 1);
        chk("t4_idle_rd", 32'(fb_rd), 0);
        strict = 1'b0;
        push_rp(0, 1);
        en = 1'b1;
        drain("t4_resume", 1000);

        // reset asserted during row 1 DISPLAY
        do_reset();
        push_rp(0, 0);
        push_rp(0, 1);
        push_rp(1, 0);
        rst = 1'b0;
        k = 0;
        while (!(row_addr == 5'd1 && oe == 1'b0) && k < 1000) begin
            tick(1);
            k++;
        end
        chk("t5_reach_row1_display", 32'(k < 1000), 1);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("t5_oe", 32'(oe), 1);
        chk("t5_lat", 32'(lat), 0);
        chk("t5_sclk", 32'(sclk), 0);
        chk("t5_row_addr", 32'(row_addr), 0);
        chk("t5_fb_addr", 32'(fb_addr), 0);
        do_reset();
        push_rp(0, 0);
        rst = 1'b0;
        drain("t5_restart", 1000);

`ifdef HUB75_BRIGHTNESS_EN
        // half brightness: plane 0 low for 2 of 4, plane 1 low for 4 of 8
        do_reset();
        bright = 128;
        brightness = 8'd128;
        for (int i = 0; i < 256; i++) mem[i] = 6'h3F;
        push_rp(0, 0);
        push_rp(0, 1);
        rst = 1'b0;
        drain("t6_half", 1000);
        // zero brightness: oe never low over a whole frame
        do_reset();
        bright = 0;
        brightness = 8'd0;
        rst = 1'b0;
        fd0 = fd_cnt;
        lo0 = oe_low;
        k = 0;
        while (fd_cnt == fd0 && k < 2000) begin
            tick(1);
            k++;
        end
        chk("t6_zero_frame_seen", 32'(k < 2000), 1);
        chk("t6_zero_oe_low", oe_low - lo0, 0);
`else
        lo0 = oe_low;
        chk("oe_low_seen", 32'(lo0 > 0), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
